// File: rtl/prog_loader.sv
// Program loader: receives a LEN/DATA/CSUM byte frame and writes the data into program memory.
// All outputs are registered; in_ready_o is high only while a frame is being received.
module prog_loader #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_wdata_o,
  output logic       cpu_reset_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] tmo_q, tmo_d;
  logic        in_ready_q, busy_q, done_q, err_q, cpu_reset_q, mem_we_q;
  logic        in_ready_d, busy_d, done_d, err_d, cpu_reset_d, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        accept;

  assign accept = in_valid_i & in_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN;
          tmo_d   = 16'd0;
        end
      end
      S_LEN, S_DATA, S_CSUM: begin
        // An accept on the timeout cycle takes priority and restarts the count.
        if (accept) begin
          tmo_d = 16'd0;
          case (state_q)
            S_LEN: begin
              if (in_data_i == 8'd0) begin
                state_d = S_ERR;
              end else begin
                len_d   = in_data_i;
                idx_d   = 8'd0;
                sum_d   = 8'd0;
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = idx_q;
              mem_wdata_d = in_data_i;
              sum_d       = sum_q + in_data_i;
              if (idx_q == len_q - 8'd1) begin
                state_d = S_CSUM;
              end else begin
                idx_d = idx_q + 8'd1;
              end
            end
            default: begin
              state_d = (in_data_i == sum_q) ? S_DONE : S_ERR;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered versions of the next state.
    in_ready_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    busy_d      = in_ready_d;
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      sum_q       <= 8'd0;
      tmo_q       <= 16'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cpu_reset_o = cpu_reset_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: TIMEOUT, default 1024, idle cycles without an accepted byte before a load aborts (range 2..65535).
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled only on rising clk.
REQ-005 start  in  1  single-cycle request to begin a program load.
REQ-006 in_valid  in  1  host byte valid.
REQ-007 in_data  in  8  host byte.
REQ-008 in_ready  out  1  loader can accept a byte this cycle.
REQ-009 mem_we  out  1  program-memory write strobe, one cycle per data byte.
REQ-010 mem_addr  out  8  program-memory write address.
REQ-011 mem_wdata  out  8  program-memory write data.
REQ-012 cpu_reset  out  1  active-high reset to the CPU; held while no valid image is loaded.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  last load completed with a good checksum.
REQ-015 err  out  1  last load failed (zero length, bad checksum or timeout).

Function
REQ-016 Frame format: LEN byte N (1..255), then N data bytes, then CSUM byte = 8-bit sum of the data bytes, modulo 256.
REQ-017 A byte is accepted only on a cycle where in_valid=1 and in_ready=1; in_valid without in_ready has no effect.
REQ-018 States: IDLE, LEN, DATA, CSUM, DONE, ERR; in_ready=1 and busy=1 only in LEN, DATA and CSUM.
REQ-019 IDLE: start=1 -> LEN; otherwise remain in IDLE.
REQ-020 LEN: on accept, N=0 -> ERR; otherwise store N, clear the index and running sum, and go to DATA.
REQ-021 DATA: on each accept, the cycle after acceptance drives mem_we=1, mem_addr=index and mem_wdata=byte; index increments and sum accumulates modulo 256.
REQ-022 DATA: acceptance of byte N-1 (index = N-1) -> CSUM; index never wraps past N-1.
REQ-023 CSUM: on accept, byte = sum -> DONE, otherwise -> ERR.
REQ-024 mem_we is 0 in every cycle not covered by REQ-021; mem_addr and mem_wdata hold their last values when mem_we=0.
REQ-025 Timeout: in LEN, DATA or CSUM, a counter clears on every accept and entry to LEN, increments otherwise; reaching TIMEOUT-1 without an accept -> ERR on the next edge.
REQ-026 Timeout versus accept in the same cycle: the accept wins and the counter clears.
REQ-027 cpu_reset=0 only while in DONE; it is 1 in all other states, and it asserts on the same edge that leaves DONE.
REQ-028 done=1 only in DONE; err=1 only in ERR.
REQ-029 DONE or ERR: start=1 -> LEN, clearing done/err and reasserting cpu_reset on that edge.
REQ-030 start in LEN, DATA or CSUM is ignored.
REQ-031 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-032 reset=0 at a rising edge -> state IDLE, and all outputs take their reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0; the counter, index and sum clear.
REQ-033 Reset mid-load aborts without further writes: mem_we=0 from that edge on, and there is no partial done/err indication.
REQ-034 start and in_valid are ignored while reset=0; after release, the loader waits in IDLE for start.

Verification
REQ-035 Good load: start, then LEN=3, data 0x11, 0x22, 0x33, CSUM=0x66 -> writes (0,0x11), (1,0x22), (2,0x33); done=1, cpu_reset=0, err=0.
REQ-036 Bad checksum: same frame with CSUM=0x67 -> three writes occur, then err=1, cpu_reset stays 1, done=0.
REQ-037 Zero length: start, then LEN=0 -> err=1 the cycle after acceptance, with no mem_we pulse.
REQ-038 Backpressure and timeout (TIMEOUT=16): in_valid toggled with gaps under 15 cycles completes the load; a 16-cycle gap in DATA -> err=1.
REQ-039 Reset during DATA after 2 of 4 bytes -> no further mem_we pulses, and all outputs are at reset values; a subsequent full load succeeds.
REQ-040 Reload and sum wrap: from DONE, start, then LEN=2, data 0xF0, 0x20, CSUM=0x10 -> cpu_reset=1 during the load, then done=1 and cpu_reset=0.
